counter_timestamp_capture: RTL and testbench

Downstream consumer of the 32-bit up counter: on each rising edge of an asynchronous event input it captures the counter value, extended with an epoch (overflow) count, into a small FIFO. Captured timestamps are read out through a valid/ready handshake. It sits between the free-running counter and any host/logger that needs event timestamps.

---
 rtl/counter_timestamp_capture.sv | 177 +++++++++++++++++
 tb/tb_counter_timestamp_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_timestamp_capture.sv
// Purpose : timestamps each rising edge of an async event as {epoch, count_in} into a show-ahead FIFO.
// Latency : push SYNC_STAGES edges after event_in is first sampled high; ts_valid follows the push edge.
// Backpr. : ts_valid/ts_ready handshake; when the FIFO is full and not popping, new events are dropped and counted.
//
// Ports:
//   clk, rst       - single clock; synchronous active-high reset
//   count_in       - free-running counter value, sampled every clock
//   overflow_in    - counter overflow flag; each 0->1 transition advances the epoch
//   event_in       - asynchronous event; each rising edge requests a capture
//   clear          - synchronous flush of FIFO, epoch and drop counter
//   ts_data/ts_valid/ts_ready - head-of-FIFO timestamp and handshake
//   fifo_level, full, empty   - FIFO occupancy
//   dropped_cnt    - saturating count of events lost to a full FIFO
module counter_timestamp_capture #(
  parameter int WIDTH       = 32,
  parameter int EPOCH_WIDTH = 16,
  parameter int DEPTH       = 8,   // power of 2, >= 2
  parameter int SYNC_STAGES = 2    // >= 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             count_in,
  input  logic                         overflow_in,
  input  logic                         event_in,
  input  logic                         clear,
  output logic [EPOCH_WIDTH+WIDTH-1:0] ts_data,
  output logic                         ts_valid,
  input  logic                         ts_ready,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         full,
  output logic                         empty,
  output logic [15:0]                  dropped_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TS_W  = EPOCH_WIDTH + WIDTH;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    evt_dly_q;
  logic                    ovf_dly_q;
  logic [EPOCH_WIDTH-1:0]  epoch_q,   epoch_d;
  logic [PTR_W-1:0]        wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q,  rd_ptr_d;
  logic [LVL_W-1:0]        level_q,   level_d;
  logic [15:0]             dropped_q, dropped_d;
  logic [TS_W-1:0]         mem_q [DEPTH];

  // ---------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------
  logic                   evt_rise;
  logic                   ovf_rise;
  logic [EPOCH_WIDTH-1:0] epoch_cap;
  logic [TS_W-1:0]        cap_word;
  logic                   pop;
  logic                   push_ok;
  logic                   drop;
  logic                   mem_we;

  always_comb begin
    evt_rise = sync_q[SYNC_STAGES-1] & ~evt_dly_q;
    ovf_rise = overflow_in & ~ovf_dly_q;
    // A capture coinciding with an overflow belongs to the new epoch.
    epoch_cap = epoch_q + EPOCH_WIDTH'(ovf_rise);
    cap_word  = {epoch_cap, count_in};

    full  = (level_q == DEPTH_L);
    empty = (level_q == '0);

    pop = ~empty & ts_ready;
    // At full a concurrent pop frees the slot being written this cycle.
    push_ok = evt_rise & (~full | pop);
    drop    = evt_rise & full & ~pop;
    mem_we  = push_ok & ~clear & ~rst;
  end

  // ---------------------------------------------------------------
  // Next-state logic (clear beats push/pop)
  // ---------------------------------------------------------------
  always_comb begin
    epoch_d   = epoch_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    dropped_d = dropped_q;

    if (clear) begin
      epoch_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      dropped_d = '0;
    end else begin
      if (ovf_rise) begin
        epoch_d = epoch_q + 1'b1;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;   // DEPTH is a power of 2, so pointers wrap naturally
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop && (dropped_q != 16'hFFFF)) begin
        dropped_d = dropped_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------
  // Synchronizer, event delay and overflow delay are untouched by clear so an
  // event already in flight still lands after a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      evt_dly_q <= 1'b0;
      ovf_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], event_in};
      evt_dly_q <= sync_q[SYNC_STAGES-1];
      ovf_dly_q <= overflow_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dropped_q <= '0;
    end else begin
      epoch_q   <= epoch_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage needs no reset: entries are only visible while the level says so.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= cap_word;
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  always_comb begin
    ts_valid    = ~empty;
    ts_data     = empty ? '0 : mem_q[rd_ptr_q];
    fifo_level  = level_q;
    dropped_cnt = dropped_q;
  end

`ifndef SYNTHESIS
  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    level_q <= DEPTH_L);

  a_data_hold: assert property (@(posedge clk) disable iff (rst || clear)
    (ts_valid && !ts_ready) |=> (ts_valid && ts_data == $past(ts_data)));
`endif

endmodule

// File: tb/tb_counter_timestamp_capture.sv
// Directed bench for counter_timestamp_capture with a pop-side scoreboard.
// Stimulus pushes each expected timestamp into a queue when an event is issued;
// a negedge monitor compares ts_data against the queue head on every handshake.
module tb_counter_timestamp_capture;

  logic        clk;
  logic        rst;
  logic [31:0] count_in;
  logic        overflow_in;
  logic        event_in;
  logic        clear;
  logic [47:0] ts_data;
  logic        ts_valid;
  logic        ts_ready;
  logic [3:0]  fifo_level;
  logic        full;
  logic        empty;
  logic [15:0] dropped_cnt;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q [$];

  counter_timestamp_capture #(
    .WIDTH(32), .EPOCH_WIDTH(16), .DEPTH(8), .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .overflow_in (overflow_in),
    .event_in    (event_in),
    .clear       (clear),
    .ts_data     (ts_data),
    .ts_valid    (ts_valid),
    .ts_ready    (ts_ready),
    .fifo_level  (fifo_level),
    .full        (full),
    .empty       (empty),
    .dropped_cnt (dropped_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge. The counter
  // model raises overflow_in for the cycle in which it has wrapped to zero.
  task automatic tick();
    @(posedge clk);
    #1;
    count_in    = count_in + 32'd1;
    overflow_in = (count_in == 32'h0);
  endtask

  // One well-spaced event: high for 1 cycle, then 3 low cycles, returning
  // one edge after the push edge. Stored count is the count at issue + 2.
  task automatic fire(input logic [47:0] expv, input bit accepted);
    if (accepted) exp_q.push_back(expv);
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && ts_valid && ts_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h, required no data", ts_data);
      end else begin
        chk("pop_data", {16'h0, ts_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; count_in = 32'hF0; overflow_in = 1'b0;
    event_in = 1'b1; clear = 1'b0; ts_ready = 1'b0;

    // ---------------- Reset with event_in toggling ----------------
    tick();
    event_in = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_valid",   {63'h0, ts_valid}, 64'h0);
    chk("rst_data",    {16'h0, ts_data},  64'h0);
    chk("rst_level",   {60'h0, fifo_level}, 64'h0);
    chk("rst_empty",   {63'h0, empty},    64'h1);
    chk("rst_full",    {63'h0, full},     64'h0);
    chk("rst_dropped", {48'h0, dropped_cnt}, 64'h0);
    repeat (4) tick();
    chk("rst_no_capture", {60'h0, fifo_level}, 64'h0);

    // ---------------- Single capture ----------------
    count_in = 32'h104;
    tick();                                   // count_in = 0x105
    exp_q.push_back(48'h0000_0000_0107);
    event_in = 1'b1;
    tick();                                   // E0 samples 0x105
    event_in = 1'b0;
    tick();                                   // E0+1
    chk("single_no_bypass", {63'h0, ts_valid}, 64'h0);
    tick();                                   // E0+2: push
    chk("single_valid", {63'h0, ts_valid}, 64'h1);
    chk("single_level", {60'h0, fifo_level}, 64'h1);
    chk("single_data",  {16'h0, ts_data}, 64'h0000_0000_0107);
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    chk("single_empty_after_pop", {63'h0, empty}, 64'h1);
    chk("single_data_zero",       {16'h0, ts_data}, 64'h0);

    // ---------------- Epoch rollover ----------------
    ts_ready = 1'b1;
    count_in = 32'hFFFF_FFFD;
    tick();                                   // 0xFFFFFFFE at issue -> push sees 0
    fire(48'h0001_0000_0000, 1'b1);
    while (count_in != 32'h0000_000E) tick();
    fire(48'h0001_0000_0010, 1'b1);
    tick();
    chk("epoch_drained", {63'h0, empty}, 64'h1);
    ts_ready = 1'b0;

    // ---------------- Full / drop ----------------
    for (int i = 0; i < 8; i++) fire({16'h0001, count_in + 32'd2}, 1'b1);
    chk("full_flag",  {63'h0, full}, 64'h1);
    chk("full_level", {60'h0, fifo_level}, 64'h8);
    chk("full_no_drop_yet", {48'h0, dropped_cnt}, 64'h0);
    fire({16'h0001, count_in + 32'd2}, 1'b0);
    chk("drop_count", {48'h0, dropped_cnt}, 64'h1);
    chk("drop_level", {60'h0, fifo_level}, 64'h8);

    // ---------------- Push + pop at full ----------------
    exp_q.push_back({16'h0001, count_in + 32'd2});
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tick();
    ts_ready = 1'b1;                          // pop in the push cycle
    tick();
    ts_ready = 1'b0;
    tick();
    chk("pp_level",   {60'h0, fifo_level}, 64'h8);
    chk("pp_dropped", {48'h0, dropped_cnt}, 64'h1);
    ts_ready = 1'b1;
    repeat (8) tick();
    ts_ready = 1'b0;
    chk("pp_drain_empty", {63'h0, empty}, 64'h1);
    chk("pp_queue_empty", 64'(exp_q.size()), 64'h0);

    // ---------------- clear mid-operation ----------------
    count_in = 32'hFFFF_FFFE;
    tick();                                   // 0xFFFFFFFF
    tick();                                   // 0, overflow_in high
    tick();                                   // epoch -> 2
    for (int i = 0; i < 3; i++) fire({16'h0002, count_in + 32'd2}, 1'b1);
    chk("clr_pre_level", {60'h0, fifo_level}, 64'h3);
    begin
      logic [31:0] c0;
      c0 = count_in;
      event_in = 1'b1;
      tick();                                 // E0
      event_in = 1'b0;
      clear = 1'b1;
      tick();                                 // clear edge, event in synchronizer
      clear = 1'b0;
      exp_q.delete();
      chk("clr_empty",   {63'h0, empty}, 64'h1);
      chk("clr_level",   {60'h0, fifo_level}, 64'h0);
      chk("clr_dropped", {48'h0, dropped_cnt}, 64'h0);
      exp_q.push_back({16'h0000, c0 + 32'd2});
      tick();                                 // in-flight push
      chk("clr_inflight_level", {60'h0, fifo_level}, 64'h1);
      ts_ready = 1'b1;
      tick();
      ts_ready = 1'b0;
      chk("clr_inflight_drained", {63'h0, empty}, 64'h1);
    end

    // ---------------- push coinciding with clear is discarded ----------------
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    tick();
    clear = 1'b1;
    tick();                                   // push edge and clear together
    clear = 1'b0;
    tick();
    chk("clr_push_discard_level", {60'h0, fifo_level}, 64'h0);
    chk("clr_push_discard_valid", {63'h0, ts_valid}, 64'h0);

    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
